// File: rtl/gemm_seq_pkg.sv
// GEMM PE sequencer shared definitions: FSM state encoding and default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gemm_seq_pkg;

  localparam int unsigned IN_DATA_WIDTH_DEF  = 8;
  localparam int unsigned NUM_INPUTS_DEF     = 4;
  localparam int unsigned OUT_DATA_WIDTH_DEF = 32;
  localparam int unsigned K_WIDTH_DEF        = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STREAM  = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_OUTPUT  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/gemm_pe_sequencer.sv
// Sequences one dot-product job: joins the A/B operand streams into a MAC PE, then captures and offers the result.
// Latency: res_valid_o rises 3 cycles after the last joined beat (2 cycles after start for an empty job).
// Backpressure: operands transfer only when both streams are valid; the result is held until res_ready_i.
module gemm_pe_sequencer
  import gemm_seq_pkg::*;
#(
  parameter int unsigned InDataWidth  = IN_DATA_WIDTH_DEF,
  parameter int unsigned NumInputs    = NUM_INPUTS_DEF,
  parameter int unsigned OutDataWidth = OUT_DATA_WIDTH_DEF,
  parameter int unsigned KWidth       = K_WIDTH_DEF
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              start_i,
  input  logic [KWidth-1:0]                 k_len_i,
  output logic                              busy_o,
  output logic                              done_o,
  input  logic [NumInputs*InDataWidth-1:0]  a_data_i,
  input  logic                              a_valid_i,
  output logic                              a_ready_o,
  input  logic [NumInputs*InDataWidth-1:0]  b_data_i,
  input  logic                              b_valid_i,
  output logic                              b_ready_o,
  output logic [NumInputs*InDataWidth-1:0]  pe_a_o,
  output logic [NumInputs*InDataWidth-1:0]  pe_b_o,
  output logic                              pe_a_valid_o,
  output logic                              pe_b_valid_o,
  output logic                              pe_init_save_o,
  output logic                              pe_acc_clr_o,
  input  logic [OutDataWidth-1:0]           pe_c_i,
  output logic [OutDataWidth-1:0]           res_data_o,
  output logic                              res_valid_o,
  input  logic                              res_ready_i
);

  localparam int unsigned BeatWidth = NumInputs * InDataWidth;

  seq_state_e              state_q, state_d;
  logic [KWidth-1:0]       cnt_q, cnt_d;
  logic                    first_q, first_d;
  logic                    zero_job_q, zero_job_d;
  logic [OutDataWidth-1:0] res_q, res_d;

  logic [BeatWidth-1:0]    pe_a_q, pe_b_q;
  logic                    pe_vld_q;
  logic                    pe_init_q;

  logic                    in_stream;
  logic                    fire;

  // A beat only moves when both streams offer data, so neither side can slip ahead of the other.
  assign in_stream = (state_q == ST_STREAM);
  assign fire      = in_stream & a_valid_i & b_valid_i;

  // Next-state, beat counter, result capture and handshake outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    first_d      = first_q;
    zero_job_d   = zero_job_q;
    res_d        = res_q;
    busy_o       = (state_q != ST_IDLE);
    a_ready_o    = in_stream & b_valid_i;
    b_ready_o    = in_stream & a_valid_i;
    pe_acc_clr_o = 1'b0;
    res_valid_o  = 1'b0;
    done_o       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          cnt_d      = k_len_i;
          first_d    = 1'b1;
          zero_job_d = (k_len_i == '0);
          // An empty job never touches the PE and goes straight to capture.
          state_d    = (k_len_i == '0) ? ST_CAPTURE : ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (fire) begin
          cnt_d   = cnt_q - KWidth'(1);
          first_d = 1'b0;
          if (cnt_q == KWidth'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // One cycle for the PE to fold in the last registered beat.
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // The PE may hold stale data on an empty job, so force zero there.
        res_d        = zero_job_q ? '0 : pe_c_i;
        pe_acc_clr_o = 1'b1;
        state_d      = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        res_valid_o = 1'b1;
        if (res_ready_i) begin
          done_o  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, beat counter and result register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      first_q    <= 1'b0;
      zero_job_q <= 1'b0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      zero_job_q <= zero_job_d;
      res_q      <= res_d;
    end
  end

  // PE operand registers: load on a joined beat, otherwise hold with valids low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pe_a_q    <= '0;
      pe_b_q    <= '0;
      pe_vld_q  <= 1'b0;
      pe_init_q <= 1'b0;
    end else begin
      pe_vld_q  <= fire;
      pe_init_q <= fire & first_q;
      if (fire) begin
        pe_a_q <= a_data_i;
        pe_b_q <= b_data_i;
      end
    end
  end

  assign pe_a_o         = pe_a_q;
  assign pe_b_o         = pe_b_q;
  assign pe_a_valid_o   = pe_vld_q;
  assign pe_b_valid_o   = pe_vld_q;
  assign pe_init_save_o = pe_init_q;
  assign res_data_o     = res_q;

endmodule

// File: tb/tb_gemm_pe_sequencer.sv
// Self-checking bench for gemm_pe_sequencer with a behavioural MAC PE.
// Latency: checks result timing relative to the last joined beat.
// Backpressure: exercises operand gaps and a stalled result handshake.
module tb_gemm_pe_sequencer;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [15:0] k_len_i;
  logic        busy_o, done_o;
  logic [31:0] a_data_i, b_data_i;
  logic        a_valid_i, a_ready_o, b_valid_i, b_ready_o;
  logic [31:0] pe_a_o, pe_b_o;
  logic        pe_a_valid_o, pe_b_valid_o, pe_init_save_o, pe_acc_clr_o;
  logic [31:0] pe_c_i;
  logic [31:0] res_data_o;
  logic        res_valid_o, res_ready_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gemm_pe_sequencer #(
    .InDataWidth (8),
    .NumInputs   (4),
    .OutDataWidth(32),
    .KWidth      (16)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .k_len_i       (k_len_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .a_data_i      (a_data_i),
    .a_valid_i     (a_valid_i),
    .a_ready_o     (a_ready_o),
    .b_data_i      (b_data_i),
    .b_valid_i     (b_valid_i),
    .b_ready_o     (b_ready_o),
    .pe_a_o        (pe_a_o),
    .pe_b_o        (pe_b_o),
    .pe_a_valid_o  (pe_a_valid_o),
    .pe_b_valid_o  (pe_b_valid_o),
    .pe_init_save_o(pe_init_save_o),
    .pe_acc_clr_o  (pe_acc_clr_o),
    .pe_c_i        (pe_c_i),
    .res_data_o    (res_data_o),
    .res_valid_o   (res_valid_o),
    .res_ready_i   (res_ready_i)
  );

  // Behavioural MAC PE; starts from junk so init_save has to do its job.
  logic signed [31:0] pe_acc = 32'sh1234_5678;

  function automatic logic signed [31:0] dot4(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] s;
    logic signed [7:0]  ea, eb;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      ea = a[i*8 +: 8];
      eb = b[i*8 +: 8];
      s  = s + ea * eb;
    end
    return s;
  endfunction

  always @(posedge clk) begin
    if (pe_acc_clr_o)
      pe_acc <= 0;
    else if (pe_a_valid_o)
      pe_acc <= (pe_init_save_o ? 32'sd0 : pe_acc) + dot4(pe_a_o, pe_b_o);
  end

  assign pe_c_i = pe_acc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    logic [15:0] k;
    logic [31:0] a;
    logic [31:0] b;
    int          gap_a;
    int          gap_b;
    int          rdy_delay;
    bit          poke_start;
    logic [31:0] exp_res;
  } job_t;

  function automatic job_t mk(input logic [15:0] k, input logic [31:0] a, input logic [31:0] b,
                              input int ga, input int gb, input int rd, input bit ps,
                              input logic [31:0] e);
    job_t j;
    j.k = k; j.a = a; j.b = b; j.gap_a = ga; j.gap_b = gb;
    j.rdy_delay = rd; j.poke_start = ps; j.exp_res = e;
    return j;
  endfunction

  // Drives one job cycle by cycle; inputs change on the falling edge, outputs sampled 1 time unit later.
  task automatic run_job(input job_t v, input string tag);
    int a_sent, b_sent, a_idle, b_idle;
    int pe_beats, inits, init_bad, clrs, onesided;
    int last_fire, rv_cyc, stall, hold_bad, early_done, done_cnt;
    logic [31:0] res_seen;
    bit fin;
    a_sent = 0; b_sent = 0; a_idle = 0; b_idle = 0;
    pe_beats = 0; inits = 0; init_bad = 0; clrs = 0; onesided = 0;
    last_fire = -1; rv_cyc = -1; stall = 0; hold_bad = 0; early_done = 0; done_cnt = 0;
    res_seen = '0; fin = 1'b0;
    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      @(negedge clk);
      start_i     = (cyc == 0);
      k_len_i     = v.k;
      a_valid_i   = (a_sent < int'(v.k)) && (a_idle == 0);
      b_valid_i   = (b_sent < int'(v.k)) && (b_idle == 0);
      a_data_i    = a_valid_i ? v.a : $urandom();
      b_data_i    = b_valid_i ? v.b : $urandom();
      res_ready_i = res_valid_o && (stall >= v.rdy_delay);
      if (v.poke_start && res_valid_o && stall == 2) begin
        start_i = 1'b1;
        k_len_i = 16'd7;
      end
      #1;
      if (pe_a_valid_o) pe_beats++;
      if (pe_init_save_o) begin
        inits++;
        if (!pe_a_valid_o || pe_beats != 1) init_bad++;
      end
      if (pe_a_valid_o !== pe_b_valid_o) onesided++;
      if ((a_valid_i && a_ready_o) !== (b_valid_i && b_ready_o)) onesided++;
      if (pe_acc_clr_o) clrs++;
      if (a_valid_i && a_ready_o && b_valid_i && b_ready_o) last_fire = cyc;
      if (a_valid_i && a_ready_o) begin
        a_sent++; a_idle = v.gap_a;
      end else if (!a_valid_i && a_idle > 0) begin
        a_idle--;
      end
      if (b_valid_i && b_ready_o) begin
        b_sent++; b_idle = v.gap_b;
      end else if (!b_valid_i && b_idle > 0) begin
        b_idle--;
      end
      if (res_valid_o) begin
        if (rv_cyc < 0) begin
          rv_cyc   = cyc;
          res_seen = res_data_o;
        end else if (res_data_o !== res_seen) begin
          hold_bad++;
        end
        if (!busy_o) hold_bad++;
        if (!res_ready_i) stall++;
      end
      if (done_o) begin
        if (!(res_valid_o && res_ready_i)) early_done++;
        done_cnt++;
        fin = 1'b1;
      end else if (res_valid_o && res_ready_i) begin
        early_done++;
      end
    end
    check({tag, "_done"}, done_cnt, 1);
    check({tag, "_result"}, res_seen, v.exp_res);
    check({tag, "_pe_beats"}, pe_beats, v.k);
    check({tag, "_init_count"}, inits, (v.k != 0) ? 1 : 0);
    check({tag, "_init_first_only"}, init_bad, 0);
    check({tag, "_joined"}, onesided, 0);
    check({tag, "_acc_clr"}, clrs, 1);
    check({tag, "_latency"}, rv_cyc, (v.k == 0) ? 2 : last_fire + 3);
    check({tag, "_hold"}, hold_bad, 0);
    check({tag, "_done_handshake"}, early_done, 0);
    @(negedge clk);
    start_i = 1'b0; a_valid_i = 1'b0; b_valid_i = 1'b0; res_ready_i = 1'b0;
    #1;
    check({tag, "_idle_after"}, {busy_o, res_valid_o}, 2'b00);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl_zero"},
          {busy_o, done_o, a_ready_o, b_ready_o, pe_a_valid_o, pe_b_valid_o,
           pe_init_save_o, pe_acc_clr_o, res_valid_o}, 9'd0);
    check({tag, "_operands_zero"}, {pe_a_o, pe_b_o}, 64'd0);
    check({tag, "_result_zero"}, res_data_o, 32'd0);
  endtask

  // Starts a 4-beat job, lets three beats fire, then resets asynchronously mid-cycle.
  task automatic reset_midstream(input string tag);
    @(negedge clk);
    start_i = 1'b1; k_len_i = 16'd4;
    a_valid_i = 1'b1; b_valid_i = 1'b1;
    a_data_i = 32'h0101_0101; b_data_i = 32'h0101_0101;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check({tag, "_busy_before_rst"}, {busy_o, pe_a_valid_o}, 2'b11);
    #1;
    rst_i = 1'b1;
    #1;
    check_all_zero(tag);
    @(negedge clk);
    a_valid_i = 1'b0; b_valid_i = 1'b0;
    rst_i = 1'b0;
  endtask

  job_t jobs[7];

  initial begin
    rst_i = 1'b1; start_i = 1'b0; k_len_i = 16'd5;
    a_valid_i = 1'b1; b_valid_i = 1'b1; res_ready_i = 1'b1;
    a_data_i = 32'hFFFF_FFFF; b_data_i = 32'hFFFF_FFFF;

    jobs[0] = mk(16'd1, 32'h0403_0201, 32'h0101_0101, 0, 0, 0, 1'b0, 32'd10);
    jobs[1] = mk(16'd3, 32'h0101_0101, 32'h0101_0101, 2, 0, 0, 1'b0, 32'd12);
    jobs[2] = mk(16'd2, 32'h8080_8080, 32'h8080_8080, 0, 0, 0, 1'b0, 32'd131072);
    jobs[3] = mk(16'd5, 32'h04FD_02FF, 32'h0807_0605, 0, 1, 0, 1'b0, 32'd90);
    jobs[4] = mk(16'd0, 32'h0101_0101, 32'h0101_0101, 0, 0, 0, 1'b0, 32'd0);
    jobs[5] = mk(16'd1, 32'h0403_0201, 32'h0101_0101, 0, 0, 5, 1'b1, 32'd10);
    jobs[6] = mk(16'd4, 32'h7F7F_7F7F, 32'h8080_8080, 1, 3, 2, 1'b0, 32'hFFFC_0800);

    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_i = 1'b0; a_valid_i = 1'b0; b_valid_i = 1'b0; res_ready_i = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_job(jobs[i], $sformatf("job%0d", i));
    end

    reset_midstream("rst1");
    run_job(jobs[0], "post_rst_k1");
    reset_midstream("rst2");
    run_job(jobs[4], "post_rst_k0");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gemm_pe_sequencer.md
GEMM_PE_SEQUENCER -- requirements
Module: gemm_pe_sequencer

Interface
REQ-001 SHALL have parameter InDataWidth, default 8: width of one operand element.
REQ-002 SHALL have parameter NumInputs, default 4: element pairs per beat.
REQ-003 SHALL have parameter OutDataWidth, default 32: width of the accumulated result.
REQ-004 SHALL have parameter KWidth, default 16: width of the beat count.
REQ-005 SHALL have port clk_i  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst_i  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port start_i  in  1  job start request.
REQ-008 SHALL have port k_len_i  in  KWidth  beats in the job; sampled when start is accepted.
REQ-009 SHALL have port busy_o  out  1  high whenever the FSM is not in IDLE.
REQ-010 SHALL have port done_o  out  1  one-cycle pulse when the result handshake completes.
REQ-011 SHALL have ports a_data_i and b_data_i  in  NumInputs*InDataWidth  signed packed operand beats.
REQ-012 SHALL have ports a_valid_i/a_ready_o and b_valid_i/b_ready_o  1 each  valid/ready handshakes for the operand streams.
REQ-013 SHALL have ports pe_a_o and pe_b_o  out  NumInputs*InDataWidth  operands driven to the MAC PE.
REQ-014 SHALL have ports pe_a_valid_o, pe_b_valid_o, pe_init_save_o and pe_acc_clr_o  out  1 each  PE control.
REQ-015 SHALL have port pe_c_i  in  OutDataWidth  PE accumulator output.
REQ-016 SHALL have ports res_data_o  out  OutDataWidth, res_valid_o  out  1 and res_ready_i  in  1  result stream.

Function
REQ-017 SHALL implement FSM states IDLE, STREAM, DRAIN, CAPTURE and OUTPUT.
REQ-018 IDLE: start_i with k_len_i != 0 SHALL latch the beat counter and go to STREAM; start_i with k_len_i == 0 SHALL go to CAPTURE.
REQ-019 start_i SHALL be ignored in every state except IDLE.
REQ-020 Beat fire SHALL equal STREAM && a_valid_i && b_valid_i; a_ready_o SHALL equal STREAM && b_valid_i; b_ready_o SHALL equal STREAM && a_valid_i (joined streams, never a one-sided transfer).
REQ-021 On a fire, pe_a_o/pe_b_o SHALL be registered from a_data_i/b_data_i and pe_a_valid_o/pe_b_valid_o SHALL be high in the next cycle only; without a fire the operands SHALL hold and both valids SHALL be low.
REQ-022 pe_init_save_o SHALL be high together with the PE valids for the first beat of each job only.
REQ-023 The fire of the last beat SHALL move STREAM to DRAIN; DRAIN SHALL last exactly 1 cycle and then go to CAPTURE.
REQ-024 CAPTURE SHALL last 1 cycle: res_data_o SHALL load pe_c_i (or 0 when k_len was 0), pe_acc_clr_o SHALL be high, and the next state SHALL be OUTPUT.
REQ-025 OUTPUT SHALL hold res_valid_o high and res_data_o stable until res_ready_i; on the handshake the FSM SHALL pulse done_o and return to IDLE.
REQ-026 Without stalls, res_valid_o SHALL rise 3 cycles after the cycle of the last fire.
REQ-027 Operand stalls of any length SHALL only pause beat counting, with no loss or duplication of beats.
REQ-028 The block SHALL do no arithmetic on the result; PE overflow wrap-around SHALL pass through unchanged.
REQ-029 The maximum job length SHALL be 2^KWidth-1 beats.

Reset
REQ-030 While rst_i is high the FSM SHALL be in IDLE, and every output, the counter and the result register SHALL be 0.
REQ-031 Reset SHALL take effect immediately, including mid-job; the first job after reset needs no PE clear because it starts with init_save.

Structure
REQ-032 Package gemm_seq_pkg SHALL hold the FSM state enum and the default width constants.
REQ-033 No sub-module SHALL be used; the counter and FSM SHALL be inline.

Verification
REQ-034 NumInputs=4, k_len=1, a={1,2,3,4}, b={1,1,1,1}, start in cycle 0, with a PE model -> one init_save beat, res_data_o=10, res_valid_o high in cycle 4.
REQ-035 k_len=3, a_valid gapped 2 cycles between beats, each beat a=b={1,1,1,1} -> exactly 3 PE valid cycles, init_save on the first only, result 12.
REQ-036 k_len=2, all elements -128 -> result 131072.
REQ-037 k_len=0 -> no PE valids, pe_acc_clr_o pulses once, res_data_o=0.
REQ-038 res_ready_i low for 5 cycles plus start_i pulsed during OUTPUT -> res_data_o held, start ignored, done_o after ready.
REQ-039 rst_i asserted mid-STREAM -> all outputs 0, IDLE; the next job k_len=1 gives the correct result.
